// File: rtl/spi_link_master.sv
// SPI mode-0 master: shifts one 40-bit {cmd, wdata} frame per request, MSB first,
// and captures the slave's reply into rstatus/rdata when the frame completes.
module spi_link_master #(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [7:0]  cmd,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [7:0]  rstatus,
  output logic [31:0] rdata,
  output logic        spi_clk,
  output logic        spi_cs,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  localparam int MAX_CYC = (CLK_DIV > CS_SETUP)
                         ? ((CLK_DIV > CS_HOLD) ? CLK_DIV : CS_HOLD)
                         : ((CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD);
  localparam int CW = $clog2(MAX_CYC) + 1;
  localparam logic [CW-1:0] DIV_RL   = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] SETUP_RL = CW'(CS_SETUP - 1);
  localparam logic [CW-1:0] HOLD_RL  = CW'(CS_HOLD - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_GAP
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [5:0]     bit_q, bit_d;
  logic [39:0]    tx_q, tx_d;
  logic [39:0]    rx_q, rx_d;
  logic           sclk_q, sclk_d;
  logic           cs_q, cs_d;
  logic           mosi_q, mosi_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic [7:0]     rstatus_q, rstatus_d;
  logic [31:0]    rdata_q, rdata_d;
  logic           cnt_zero;

  assign cnt_zero = (cnt_q == '0);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    sclk_d    = 1'b0;
    done_d    = 1'b0;
    rstatus_d = rstatus_q;
    rdata_d   = rdata_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          tx_d    = {cmd, wdata};
          rx_d    = '0;
          bit_d   = '0;
          cnt_d   = SETUP_RL;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (cnt_zero) begin
          cnt_d   = DIV_RL;
          state_d = ST_SHIFT;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_SHIFT: begin
        sclk_d = sclk_q;
        if (!cnt_zero) begin
          cnt_d = cnt_q - CW'(1);
        end else if (!sclk_q) begin
          // Rising SCLK edge: capture the slave's bit.
          sclk_d = 1'b1;
          rx_d   = {rx_q[38:0], spi_miso};
          cnt_d  = DIV_RL;
        end else begin
          sclk_d = 1'b0;
          if (bit_q == 6'd39) begin
            cnt_d   = HOLD_RL;
            state_d = ST_HOLD;
          end else begin
            tx_d  = {tx_q[38:0], 1'b0};
            bit_d = bit_q + 6'd1;
            cnt_d = DIV_RL;
          end
        end
      end
      ST_HOLD: begin
        if (cnt_zero) begin
          cnt_d     = DIV_RL;
          state_d   = ST_GAP;
          done_d    = 1'b1;
          rstatus_d = rx_q[39:32];
          rdata_d   = rx_q[31:0];
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_GAP: begin
        if (cnt_zero) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Pin values are registered from the next state so outputs never see inputs combinationally.
    cs_d   = !((state_d == ST_SETUP) || (state_d == ST_SHIFT) || (state_d == ST_HOLD));
    busy_d = (state_d != ST_IDLE);
    mosi_d = cs_d ? 1'b0 : tx_d[39];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
      sclk_q    <= 1'b0;
      cs_q      <= 1'b1;
      mosi_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rstatus_q <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      sclk_q    <= sclk_d;
      cs_q      <= cs_d;
      mosi_q    <= mosi_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      rstatus_q <= rstatus_d;
      rdata_q   <= rdata_d;
    end
  end

  assign spi_clk  = sclk_q;
  assign spi_cs   = cs_q;
  assign spi_mosi = mosi_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign rstatus  = rstatus_q;
  assign rdata    = rdata_q;

endmodule

// File: tb/tb_spi_link_master.sv
// Directed bench for spi_link_master: one instance at CLK_DIV=2/2/2, one at the 1/1/1 corner.
`timescale 1ns/1ps
module tb_spi_link_master;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        s_start = 1'b0;
  logic        f_start = 1'b0;
  logic [7:0]  cmd = '0;
  logic [31:0] wdata = '0;

  logic        s_busy, s_done, s_clk, s_cs, s_mosi, s_miso;
  logic [7:0]  s_rstatus;
  logic [31:0] s_rdata;
  logic        f_busy, f_done, f_clk, f_cs, f_mosi, f_miso;
  logic [7:0]  f_rstatus;
  logic [31:0] f_rdata;

  localparam logic [39:0] SLV_WORD = 40'h81_0F0F_F0F0;
  logic        miso_mode = 1'b0;
  logic [39:0] slv_sreg = '0;
  logic        slv_prev_cs = 1'b1;
  logic        slv_prev_clk = 1'b0;

  always #5 clk = ~clk;

  spi_link_master #(.CLK_DIV(2), .CS_SETUP(2), .CS_HOLD(2)) u_dut (
    .clk(clk), .reset_n(reset_n), .start(s_start), .cmd(cmd), .wdata(wdata),
    .busy(s_busy), .done(s_done), .rstatus(s_rstatus), .rdata(s_rdata),
    .spi_clk(s_clk), .spi_cs(s_cs), .spi_mosi(s_mosi), .spi_miso(s_miso)
  );

  spi_link_master #(.CLK_DIV(1), .CS_SETUP(1), .CS_HOLD(1)) u_dut_fast (
    .clk(clk), .reset_n(reset_n), .start(f_start), .cmd(cmd), .wdata(wdata),
    .busy(f_busy), .done(f_done), .rstatus(f_rstatus), .rdata(f_rdata),
    .spi_clk(f_clk), .spi_cs(f_cs), .spi_mosi(f_mosi), .spi_miso(f_miso)
  );

  // Mode-0 slave: loads its reply when CS falls, moves to the next bit after each SCLK fall.
  always @(negedge clk) begin
    if (slv_prev_cs && !s_cs) slv_sreg = SLV_WORD;
    else if (slv_prev_clk && !s_clk && !s_cs) slv_sreg = {slv_sreg[38:0], 1'b0};
    slv_prev_cs  = s_cs;
    slv_prev_clk = s_clk;
  end

  assign s_miso = miso_mode ? slv_sreg[39] : s_mosi;
  assign f_miso = f_mosi;

  logic        use_fast = 1'b0;
  logic        m_cs, m_clk, m_mosi, m_busy, m_done;
  logic [7:0]  m_rstatus;
  logic [31:0] m_rdata;
  assign m_cs      = use_fast ? f_cs      : s_cs;
  assign m_clk     = use_fast ? f_clk     : s_clk;
  assign m_mosi    = use_fast ? f_mosi    : s_mosi;
  assign m_busy    = use_fast ? f_busy    : s_busy;
  assign m_done    = use_fast ? f_done    : s_done;
  assign m_rstatus = use_fast ? f_rstatus : s_rstatus;
  assign m_rdata   = use_fast ? f_rdata   : s_rdata;

  int n_checks = 0;
  int n_pass = 0;
  int cs_low, busy_n, pulses, done_k, done_cnt, first_rise, last_high, cs_rise, mosi_viol;
  logic [39:0] mosi_bits;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Issues one start and observes every cycle (k = cycles after the accepting edge) until busy drops.
  task automatic run_frame(input logic [7:0] c, input logic [31:0] d, input logic fast, input logic poke);
    logic prev_clk, prev_mosi, ended;
    cs_low = 0; busy_n = 0; pulses = 0; done_k = -1; done_cnt = 0;
    first_rise = -1; last_high = -1; cs_rise = -1; mosi_viol = 0; mosi_bits = '0;
    ended = 1'b0;
    use_fast = fast;
    @(negedge clk);
    cmd = c;
    wdata = d;
    if (fast) f_start = 1'b1;
    else s_start = 1'b1;
    @(negedge clk);
    f_start = 1'b0;
    s_start = 1'b0;
    prev_clk = 1'b0;
    prev_mosi = 1'b0;
    for (int k = 1; k <= 400; k++) begin
      if (!m_cs) cs_low++;
      else if (cs_rise < 0 && cs_low > 0) cs_rise = k;
      if (m_busy) busy_n++;
      if (m_clk) begin
        if (!prev_clk) begin
          pulses++;
          mosi_bits = {mosi_bits[38:0], m_mosi};
          if (first_rise < 0) first_rise = k;
        end else if (m_mosi !== prev_mosi) begin
          mosi_viol++;
        end
        last_high = k;
      end
      if (m_done) begin
        done_cnt++;
        done_k = k;
      end
      prev_clk = m_clk;
      prev_mosi = m_mosi;
      if (!m_busy) begin
        ended = 1'b1;
        break;
      end
      s_start = poke && (k == 5 || k == 50 || k == 165);
      @(negedge clk);
    end
    s_start = 1'b0;
    check_val("frame_end", 64'(ended), 64'(1));
    $display("frame cmd=%02h wdata=%08h rstatus=%02h rdata=%08h done_at=%0d sclk_pulses=%0d",
             c, d, m_rstatus, m_rdata, done_k, pulses);
  endtask

  initial begin
    int dn, gap_run, min_gap, seen_low, rises, extra, busy_seen;
    logic prev, ended;

    // Reset state
    repeat (3) @(negedge clk);
    check_val("rst_cs", 64'(s_cs), 64'(1));
    check_val("rst_sclk", 64'(s_clk), 64'(0));
    check_val("rst_mosi", 64'(s_mosi), 64'(0));
    check_val("rst_busy", 64'(s_busy), 64'(0));
    check_val("rst_done", 64'(s_done), 64'(0));
    check_val("rst_rstatus", 64'(s_rstatus), 64'(0));
    check_val("rst_rdata", 64'(s_rdata), 64'(0));
    check_val("rst_fast_cs", 64'(f_cs), 64'(1));
    reset_n = 1'b1;

    // Basic frame against the slave model
    miso_mode = 1'b1;
    run_frame(8'hA5, 32'hDEADBEEF, 1'b0, 1'b0);
    check_val("basic_mosi_bits", 64'(mosi_bits), 64'(40'hA5DEADBEEF));
    check_val("basic_pulses", 64'(pulses), 64'(40));
    check_val("basic_cs_low", 64'(cs_low), 64'(164));
    check_val("basic_cs_rise", 64'(cs_rise), 64'(165));
    check_val("basic_done_at", 64'(done_k), 64'(165));
    check_val("basic_done_cnt", 64'(done_cnt), 64'(1));
    check_val("basic_busy_len", 64'(busy_n), 64'(166));
    check_val("basic_first_rise", 64'(first_rise), 64'(5));
    check_val("basic_last_high", 64'(last_high), 64'(162));
    check_val("slave_rstatus", 64'(s_rstatus), 64'(8'h81));
    check_val("slave_rdata", 64'(s_rdata), 64'(32'h0F0FF0F0));
    check_val("slave_mosi_stable", 64'(mosi_viol), 64'(0));

    // Loopback
    miso_mode = 1'b0;
    run_frame(8'h3C, 32'h12345678, 1'b0, 1'b0);
    check_val("loop_rstatus", 64'(s_rstatus), 64'(8'h3C));
    check_val("loop_rdata", 64'(s_rdata), 64'(32'h12345678));

    // Start pulses while busy are ignored
    run_frame(8'h42, 32'hCAFEF00D, 1'b0, 1'b1);
    check_val("poke_done_cnt", 64'(done_cnt), 64'(1));
    check_val("poke_busy_len", 64'(busy_n), 64'(166));
    check_val("poke_rdata", 64'(s_rdata), 64'(32'hCAFEF00D));
    busy_seen = 0;
    repeat (200) begin
      @(negedge clk);
      if (s_busy || !s_cs) busy_seen++;
    end
    check_val("poke_no_extra_frame", 64'(busy_seen), 64'(0));
    check_val("poke_rdata_hold", 64'(s_rdata), 64'(32'hCAFEF00D));

    // start held high: back-to-back frames
    @(negedge clk);
    cmd = 8'h5A;
    wdata = 32'h01020304;
    s_start = 1'b1;
    dn = 0; gap_run = 0; min_gap = 1000; seen_low = 0; ended = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (s_done) begin
        dn++;
        if (dn == 3) s_start = 1'b0;
      end
      if (!s_cs) begin
        if (seen_low != 0 && gap_run > 0 && gap_run < min_gap) min_gap = gap_run;
        seen_low = 1;
        gap_run = 0;
      end else if (seen_low != 0) begin
        gap_run++;
      end
      if (dn == 3 && !s_busy) begin
        ended = 1'b1;
        break;
      end
    end
    s_start = 1'b0;
    check_val("held_end", 64'(ended), 64'(1));
    extra = 0;
    repeat (50) begin
      @(negedge clk);
      if (s_done) extra++;
    end
    $display("held start: done pulses=%0d min cs gap=%0d rdata=%08h", dn + extra, min_gap, s_rdata);
    check_val("held_done_cnt", 64'(dn + extra), 64'(3));
    check_val("held_min_gap", 64'(min_gap), 64'(3));
    check_val("held_rdata", 64'(s_rdata), 64'(32'h01020304));

    // Reset at bit 20
    miso_mode = 1'b1;
    @(negedge clk);
    cmd = 8'h77;
    wdata = 32'hAAAA5555;
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    rises = 0;
    prev = 1'b0;
    for (int k = 0; k < 400 && rises < 20; k++) begin
      @(negedge clk);
      if (s_clk && !prev) rises++;
      prev = s_clk;
    end
    check_val("mid_rises", 64'(rises), 64'(20));
    check_val("mid_cs_before", 64'(s_cs), 64'(0));
    #2 reset_n = 1'b0;
    #1;
    check_val("mid_cs_async", 64'(s_cs), 64'(1));
    check_val("mid_sclk_async", 64'(s_clk), 64'(0));
    check_val("mid_busy_async", 64'(s_busy), 64'(0));
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    extra = 0;
    busy_seen = 0;
    repeat (200) begin
      @(negedge clk);
      if (s_done) extra++;
      if (s_busy) busy_seen++;
    end
    $display("reset mid-frame: done pulses=%0d rdata=%08h", extra, s_rdata);
    check_val("mid_no_done", 64'(extra), 64'(0));
    check_val("mid_no_busy", 64'(busy_seen), 64'(0));
    check_val("mid_rdata", 64'(s_rdata), 64'(0));
    check_val("mid_rstatus", 64'(s_rstatus), 64'(0));

    miso_mode = 1'b0;
    run_frame(8'hC3, 32'h89ABCDEF, 1'b0, 1'b0);
    check_val("post_rst_mosi_bits", 64'(mosi_bits), 64'(40'hC389ABCDEF));
    check_val("post_rst_done_at", 64'(done_k), 64'(165));
    check_val("post_rst_rstatus", 64'(s_rstatus), 64'(8'hC3));
    check_val("post_rst_rdata", 64'(s_rdata), 64'(32'h89ABCDEF));

    // CLK_DIV=1 corner
    run_frame(8'hFF, 32'h00000000, 1'b1, 1'b0);
    check_val("fast_mosi_bits", 64'(mosi_bits), 64'(40'hFF00000000));
    check_val("fast_pulses", 64'(pulses), 64'(40));
    check_val("fast_first_rise", 64'(first_rise), 64'(3));
    check_val("fast_last_high", 64'(last_high), 64'(81));
    check_val("fast_cs_low", 64'(cs_low), 64'(82));
    check_val("fast_done_at", 64'(done_k), 64'(83));
    check_val("fast_busy_len", 64'(busy_n), 64'(83));
    check_val("fast_rstatus", 64'(f_rstatus), 64'(8'hFF));
    check_val("fast_rdata", 64'(f_rdata), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
